// File: rtl/fractal_sync_pkg.sv
// Shared types and constants for the fractal_sync traffic generator.
package fractal_sync_pkg;

  // Per-port compute-unit life cycle within one iteration.
  typedef enum logic [2:0] {
    TGEN_IDLE,
    TGEN_COMP,
    TGEN_REQ,
    TGEN_WAIT,
    TGEN_DONE
  } fsync_tgen_state_e;

  // Width of the global error counter.
  localparam int TGEN_ERR_W = 16;

  // A wake or error pulse that arrives outside WAIT is spurious.
  // Each such pulse counts as one error.
  function automatic logic [1:0] spurious_count(input logic wake, input logic error);
    return {1'b0, wake} + {1'b0, error};
  endfunction

endpackage

// File: rtl/fractal_sync_tgen_port.sv
// One emulated compute unit: compute delay, one request pulse, then wait for the wake.
// Request and wake are single-cycle pulses with no back-pressure. A request is
// valid only in the cycle req is high. A wake or error is consumed in the cycle
// it is high. Nothing is held or retried.
module fractal_sync_tgen_port
  import fractal_sync_pkg::*;
#(
  parameter int LVL_WIDTH = 3,
  parameter int ID_WIDTH  = 5,
  parameter int COMP_W    = 8,
  parameter int TMO_W     = 12,
  parameter int LAT_W     = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 launch_i,
  input  logic                 finish_i,
  input  logic [COMP_W-1:0]    comp_i,
  input  logic [LVL_WIDTH-1:0] cfg_lvl_i,
  input  logic [ID_WIDTH-1:0]  cfg_id_i,
  input  logic                 wake_i,
  input  logic [LVL_WIDTH-1:0] lvl_i,
  input  logic [ID_WIDTH-1:0]  id_i,
  input  logic                 error_i,
  output logic                 in_done_o,
  output logic [1:0]           err_inc_o,
  output logic [LAT_W-1:0]     lat_max_o,
  output fsync_tgen_state_e    state_o
);

  fsync_tgen_state_e state_q, state_d;
  logic [COMP_W-1:0] comp_q, comp_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
  logic [LAT_W-1:0]  lat_q, lat_d, lat_inc;
  logic [LAT_W-1:0]  lat_max_q, lat_max_d;
  logic              mismatch;

  // Next-state, counter updates and per-cycle error increment.
  always_comb begin
    state_d   = state_q;
    comp_d    = comp_q;
    tmo_d     = tmo_q;
    lat_d     = lat_q;
    lat_max_d = lat_max_q;
    err_inc_o = 2'd0;
    lat_inc   = (lat_q == '1) ? lat_q : lat_q + 1'b1;
    tmo_inc   = tmo_q + 1'b1;
    mismatch  = (lvl_i != cfg_lvl_i) || (id_i != cfg_id_i);
    unique case (state_q)
      TGEN_IDLE: begin
        err_inc_o = spurious_count(wake_i, error_i);
        if (launch_i) begin
          state_d = TGEN_COMP;
          comp_d  = comp_i;
        end
      end
      TGEN_COMP: begin
        err_inc_o = spurious_count(wake_i, error_i);
        if (comp_q == '0) begin
          state_d = TGEN_REQ;
        end else begin
          comp_d = comp_q - 1'b1;
        end
      end
      TGEN_REQ: begin
        // A response in the request cycle cannot belong to this request.
        err_inc_o = spurious_count(wake_i, error_i);
        state_d   = TGEN_WAIT;
        tmo_d     = '0;
        lat_d     = '0;
      end
      TGEN_WAIT: begin
        lat_d = lat_inc;
        tmo_d = tmo_inc;
        if (wake_i || error_i) begin
          state_d = TGEN_DONE;
          // Error and bad wake in the same cycle still count once.
          if (error_i || (wake_i && mismatch)) begin
            err_inc_o = 2'd1;
          end
          // lat_inc is the request-to-wake distance in cycles.
          if (wake_i && (lat_inc > lat_max_q)) begin
            lat_max_d = lat_inc;
          end
        end else if (tmo_inc == '1) begin
          state_d   = TGEN_DONE;
          err_inc_o = 2'd1;
        end
      end
      TGEN_DONE: begin
        err_inc_o = spurious_count(wake_i, error_i);
        if (finish_i) begin
          state_d = TGEN_IDLE;
        end else if (launch_i) begin
          state_d = TGEN_COMP;
          comp_d  = comp_i;
        end
      end
      default: state_d = TGEN_IDLE;
    endcase
    if (clr_i) begin
      lat_max_d = '0;
    end
  end

  // State and counter registers; reset returns the port to idle with no history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= TGEN_IDLE;
      comp_q    <= '0;
      tmo_q     <= '0;
      lat_q     <= '0;
      lat_max_q <= '0;
    end else begin
      state_q   <= state_d;
      comp_q    <= comp_d;
      tmo_q     <= tmo_d;
      lat_q     <= lat_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign in_done_o = (state_q == TGEN_DONE);
  assign lat_max_o = lat_max_q;
  assign state_o   = state_q;

endmodule

// File: rtl/fractal_sync_tgen.sv
// Multi-port synchronization traffic generator.
// Ports run iteration-locked: all ports are relaunched only after every port is done.
module fractal_sync_tgen
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int AGGR_WIDTH = 6,
  parameter int LVL_WIDTH  = 3,
  parameter int ID_WIDTH   = 5,
  parameter int COMP_W     = 8,
  parameter int ITER_W     = 16,
  parameter int TMO_W      = 12,
  parameter int LAT_W      = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ITER_W-1:0]             cfg_iter_i,
  input  logic [AGGR_WIDTH-1:0]         cfg_aggr_i,
  input  logic [ID_WIDTH-1:0]           cfg_id_i,
  input  logic [LVL_WIDTH-1:0]          cfg_lvl_i,
  input  logic [N_PORTS*COMP_W-1:0]     cfg_comp_i,
  output logic [N_PORTS-1:0]            req_sync_o,
  output logic [N_PORTS*AGGR_WIDTH-1:0] req_aggr_o,
  output logic [N_PORTS*ID_WIDTH-1:0]   req_id_o,
  input  logic [N_PORTS-1:0]            rsp_wake_i,
  input  logic [N_PORTS*LVL_WIDTH-1:0]  rsp_lvl_i,
  input  logic [N_PORTS*ID_WIDTH-1:0]   rsp_id_i,
  input  logic [N_PORTS-1:0]            rsp_error_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ITER_W-1:0]             iter_o,
  output logic [TGEN_ERR_W-1:0]         err_cnt_o,
  output logic [N_PORTS*LAT_W-1:0]      lat_max_o
);

  // Extra headroom so the per-cycle sum cannot wrap before saturation.
  localparam int SUM_W = TGEN_ERR_W + 8;

  logic [ITER_W-1:0]         cfg_iter_q;
  logic [AGGR_WIDTH-1:0]     cfg_aggr_q;
  logic [ID_WIDTH-1:0]       cfg_id_q;
  logic [LVL_WIDTH-1:0]      cfg_lvl_q;
  logic [N_PORTS*COMP_W-1:0] cfg_comp_q;
  logic                      busy_q;
  logic                      done_q;
  logic [ITER_W-1:0]         iter_q;
  logic [TGEN_ERR_W-1:0]     err_q, err_d;

  logic                      start_acc;
  logic                      step;
  logic                      last;
  logic                      launch;
  logic [ITER_W-1:0]         iter_inc;
  logic [N_PORTS*COMP_W-1:0] comp_sel;
  logic [SUM_W-1:0]          err_sum;

  logic [N_PORTS-1:0]        port_done;
  logic [1:0]                port_inc   [N_PORTS];
  fsync_tgen_state_e         port_state [N_PORTS];

  // Run control: accept start, detect iteration completion, decide relaunch or finish.
  always_comb begin
    start_acc = start_i && !busy_q;
    step      = busy_q && (&port_done);
    iter_inc  = iter_q + 1'b1;
    last      = step && (iter_inc == cfg_iter_q);
    launch    = (start_acc && (cfg_iter_i != '0)) || (step && !last);
    // The first launch happens with the config being latched this cycle.
    comp_sel  = start_acc ? cfg_comp_i : cfg_comp_q;
  end

  // Saturating sum of all per-port error increments.
  always_comb begin
    err_sum = {{(SUM_W-TGEN_ERR_W){1'b0}}, err_q};
    for (int p = 0; p < N_PORTS; p++) begin
      err_sum = err_sum + SUM_W'(port_inc[p]);
    end
    err_d = (err_sum[SUM_W-1:TGEN_ERR_W] != '0) ? '1 : err_sum[TGEN_ERR_W-1:0];
  end

  // Config, iteration, busy/done and error-count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_iter_q <= '0;
      cfg_aggr_q <= '0;
      cfg_id_q   <= '0;
      cfg_lvl_q  <= '0;
      cfg_comp_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iter_q     <= '0;
      err_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_d;
      if (start_acc) begin
        cfg_iter_q <= cfg_iter_i;
        cfg_aggr_q <= cfg_aggr_i;
        cfg_id_q   <= cfg_id_i;
        cfg_lvl_q  <= cfg_lvl_i;
        cfg_comp_q <= cfg_comp_i;
        iter_q     <= '0;
        err_q      <= '0;
        busy_q     <= (cfg_iter_i != '0);
        done_q     <= (cfg_iter_i == '0);
      end else if (step) begin
        iter_q <= iter_inc;
        if (last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    fractal_sync_tgen_port #(
      .LVL_WIDTH (LVL_WIDTH),
      .ID_WIDTH  (ID_WIDTH),
      .COMP_W    (COMP_W),
      .TMO_W     (TMO_W),
      .LAT_W     (LAT_W)
    ) u_port (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (start_acc),
      .launch_i  (launch),
      .finish_i  (last),
      .comp_i    (comp_sel[p*COMP_W +: COMP_W]),
      .cfg_lvl_i (cfg_lvl_q),
      .cfg_id_i  (cfg_id_q),
      .wake_i    (rsp_wake_i[p]),
      .lvl_i     (rsp_lvl_i[p*LVL_WIDTH +: LVL_WIDTH]),
      .id_i      (rsp_id_i[p*ID_WIDTH +: ID_WIDTH]),
      .error_i   (rsp_error_i[p]),
      .in_done_o (port_done[p]),
      .err_inc_o (port_inc[p]),
      .lat_max_o (lat_max_o[p*LAT_W +: LAT_W]),
      .state_o   (port_state[p])
    );

    // Request fields are only non-zero during the request pulse.
    assign req_sync_o[p] = (port_state[p] == TGEN_REQ);
    assign req_aggr_o[p*AGGR_WIDTH +: AGGR_WIDTH] = req_sync_o[p] ? cfg_aggr_q : '0;
    assign req_id_o[p*ID_WIDTH +: ID_WIDTH]       = req_sync_o[p] ? cfg_id_q : '0;
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign iter_o    = iter_q;
  assign err_cnt_o = err_q;

endmodule

// File: doc/fractal_sync_tgen.md
Name: fractal_sync_tgen

Overview:
Synthesizable multi-port synchronization traffic generator that replaces per-CU software BFMs for FPGA emulation and long-run soak tests of fractal_sync_1d/2d trees. Each port models one compute unit. Per iteration, each port counts a programmable compute delay, issues one fsync request pulse, then waits for the matching wake. Ports are iteration-locked: a new iteration starts only when every port has been woken. The block checks wake level and id, counts errors and timeouts, and reports per-port latency maxima.

Parameters:
N_PORTS, 2, number of CU ports (>=1)
AGGR_WIDTH, 6, fsync aggregate field width
LVL_WIDTH, 3, fsync level field width
ID_WIDTH, 5, barrier id width
COMP_W, 8, compute-delay counter width
ITER_W, 16, iteration counter width
TMO_W, 12, wake-timeout counter width; all-ones value = timeout
LAT_W, 12, latency counter width, saturating

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  pulse; loads config, begins run (ignored while busy_o)
cfg_iter_i  in  ITER_W  iterations to run; 0 = run completes immediately
cfg_aggr_i  in  AGGR_WIDTH  aggregate driven on every request
cfg_id_i  in  ID_WIDTH  barrier id driven on every request
cfg_lvl_i  in  LVL_WIDTH  expected wake level
cfg_comp_i  in  N_PORTS*COMP_W  per-port compute delay in cycles
req_sync_o  out  N_PORTS  request pulse per port
req_aggr_o  out  N_PORTS*AGGR_WIDTH  aggregate per port
req_id_o  out  N_PORTS*ID_WIDTH  id per port
rsp_wake_i  in  N_PORTS  wake pulse per port
rsp_lvl_i  in  N_PORTS*LVL_WIDTH  wake level
rsp_id_i  in  N_PORTS*ID_WIDTH  wake id
rsp_error_i  in  N_PORTS  error pulse per port
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at end of run
iter_o  out  ITER_W  completed iterations
err_cnt_o  out  16  saturating count of mismatches, rsp errors, timeouts
lat_max_o  out  N_PORTS*LAT_W  max request-to-wake cycles per port

Behaviour:
- Reset: every port FSM goes to IDLE. All outputs are 0: req_*, busy_o, done_o, iter_o, err_cnt_o, lat_max_o. Config registers are cleared. Reset mid-run aborts without asserting done_o.
- start_i while not busy: latch all cfg_* and clear iter_o, err_cnt_o and lat_max_o. busy_o=1 next cycle. If cfg_iter_i==0, done_o pulses next cycle and busy_o stays 0.
- Port FSM states:
  - IDLE -> COMP on iteration launch; load the delay counter with cfg_comp.
  - COMP: decrement each cycle. With counter==0, go to REQ. A delay of 0 means REQ in the cycle after launch.
  - REQ: for exactly 1 cycle, req_sync_o[p]=1, req_aggr_o/req_id_o = latched values. Go to WAIT. Clear the latency and timeout counters.
  - WAIT: latency counter increments (saturating at all-ones) and timeout counter increments each cycle.
    - rsp_wake_i[p]: go to DONE. If rsp_lvl!=cfg_lvl or rsp_id!=cfg_id, err_cnt+1. Update lat_max if latency>lat_max.
    - rsp_error_i[p]: err_cnt+1 and go to DONE. If it coincides with wake, only one increment.
    - Timeout all-ones: err_cnt+1 and go to DONE.
  - DONE: hold until the global launch.
- Wake/error in IDLE, COMP or DONE: err_cnt+1 (spurious). Responses in the REQ cycle are treated the same way.
- Iteration control:
  - When all ports are in DONE: iter_o+1 in that cycle.
  - If iter_o+1==cfg_iter: return all ports to IDLE, pulse done_o, busy_o=0 in the same cycle.
  - Otherwise launch all ports to COMP in the next cycle.
  - Minimum iteration period = max(comp)+3+wake latency.
- err_cnt_o saturates at 0xFFFF. Multiple ports erring in the same cycle add their count, saturating.
- start_i while busy: ignored.

Decomposition:
- fractal_sync_pkg gets fsync_tgen_state_e (IDLE, COMP, REQ, WAIT, DONE) and constant TGEN_ERR_W=16.
- Sub-module fractal_sync_tgen_port (one per port) holds the FSM, compute/timeout/latency counters and the per-port lat_max register. It outputs in_done and a 2-bit error-increment.
- Top level holds config registers, iteration counter, all-done reduction and the saturating error adder.

Test Plan:
1. N_PORTS=2, comp={0,0}, iter=1, aggr=1, id=0, lvl=2; DUT wakes both ports 3 cycles after the later request with lvl=2 -> single req pulse per port, done_o 1 pulse, iter_o=1, err_cnt_o=0, lat_max={3,3}.
2. comp={2,9}, iter=4, correct wakes -> port0 request 3 cycles after launch, port1 10 cycles after; 4 requests per port; next launch only after both wakes; iter_o=4.
3. Wake with id=7 (cfg_id=0) on port1 in iteration 2 of 3 -> err_cnt_o=1, run still completes with iter_o=3.
4. Port0 never woken, TMO_W=4 -> port0 DONE after 15 WAIT cycles, err_cnt_o=1; rsp_error_i and wake in the same cycle -> +1 only.
5. Spurious wake in COMP, then start_i pulsed mid-run -> err_cnt_o+1, start ignored. rst_i mid-WAIT -> all outputs 0 next cycle, no done_o.
6. cfg_iter_i=0 -> done_o one cycle after start, no req_sync_o, busy_o never 1.
